// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator control stage and the 4-bit logic ALU:
// controller state encoding, ALU select codes and the datapath width.
package alu_pkg;

   localparam int unsigned WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOT = 2'b11;

endpackage

// File: rtl/alu.sv
// Combinational 4-bit logic ALU: AND / OR / XOR / NOT A, selected by {s1,s0}.
module alu (
   input  logic [alu_pkg::WIDTH-1:0] a,
   input  logic [alu_pkg::WIDTH-1:0] b,
   input  logic                      s1,
   input  logic                      s0,
   output logic [alu_pkg::WIDTH-1:0] out
);
   import alu_pkg::*;

   always_comb begin
      out = '0;
      case ({s1, s0})
         OP_AND:  out = a & b;
         OP_OR:   out = a | b;
         OP_XOR:  out = a ^ b;
         OP_NOT:  out = ~a;
         default: out = '0;
      endcase
   end

endmodule

// File: rtl/alu_datapath.sv
// Wrapper pairing the accumulator control stage with the logic ALU it drives.
module alu_datapath #(
   parameter int unsigned CNT_W = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_load,
   input  logic [1:0]                in_op,
   input  logic [alu_pkg::WIDTH-1:0] in_b,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [alu_pkg::WIDTH-1:0] res_data,
   output logic                      res_zero,
   output logic [CNT_W-1:0]          op_count
);
   logic [alu_pkg::WIDTH-1:0] a_w, b_w, out_w;
   logic                      s1_w, s0_w;

   alu_accumulator #(
      .WIDTH (alu_pkg::WIDTH),
      .CNT_W (CNT_W)
   ) u_ctrl (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_load   (in_load),
      .in_op     (in_op),
      .in_b      (in_b),
      .alu_a     (a_w),
      .alu_b     (b_w),
      .alu_s1    (s1_w),
      .alu_s0    (s0_w),
      .alu_out   (out_w),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_zero  (res_zero),
      .op_count  (op_count)
   );

   alu u_alu (
      .a   (a_w),
      .b   (b_w),
      .s1  (s1_w),
      .s0  (s0_w),
      .out (out_w)
   );

endmodule

// File: rtl/alu_accumulator.sv
// Control stage in front of the logic ALU: accepts one instruction over valid/ready,
// keeps operand A in an accumulator and returns each result over a second valid/ready.
module alu_accumulator #(
   parameter int unsigned WIDTH = alu_pkg::WIDTH,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_load,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_s1,
   output logic             alu_s0,
   input  logic [WIDTH-1:0] alu_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_zero,
   output logic [CNT_W-1:0] op_count
);
   import alu_pkg::*;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   acc_q,   acc_d;
   logic [WIDTH-1:0]   b_q,     b_d;
   logic [1:0]         op_q,    op_d;
   logic [WIDTH-1:0]   res_q,   res_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      b_d     = b_q;
      op_d    = op_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               b_d  = in_b;
               op_d = in_op;
               if (in_load) begin
                  acc_d   = in_b;
                  res_d   = in_b;
                  state_d = HOLD;
               end else begin
                  state_d = EXEC;
               end
            end
         end
         EXEC: begin
            acc_d   = alu_out;
            res_d   = alu_out;
            state_d = HOLD;
         end
         HOLD: begin
            if (res_ready) begin
               cnt_d   = cnt_q + 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Both handshake signals are pure decodes of the state flop, never of the inputs.
   assign in_ready  = (state_q == IDLE);
   assign res_valid = (state_q == HOLD);

   assign alu_a    = acc_q;
   assign alu_b    = b_q;
   assign alu_s1   = op_q[1];
   assign alu_s0   = op_q[0];
   assign res_data = res_q;
   assign res_zero = (res_q == '0);
   assign op_count = cnt_q;

endmodule

// File: doc/alu_accumulator.md
# alu_accumulator

Sequential control stage directly upstream of the 4-bit logic ALU (`alu`: AND/OR/XOR/NOT selected by `s1,s0`). It accepts one instruction at a time over a valid/ready handshake and drives the ALU's operand and select inputs. Operand A is always an internal 4-bit accumulator. The ALU result is captured back into the accumulator and presented downstream over a second valid/ready handshake, together with a zero flag and a completed-operation count.

## Interface
Parameters:
- `WIDTH`, 4: data width. Must equal the ALU width; only 4 is supported.
- `CNT_W`, 8: width of the completed-operation counter.

Ports (one clock `clk`; reset `rst_n` is asynchronous and active-low):
- `clk` in 1: rising-edge clock for all state.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: instruction offered.
- `in_ready` out 1: instruction accepted when `in_valid && in_ready` at a clock edge.
- `in_load` in 1: 1 means load `in_b` into the accumulator directly, with no ALU operation.
- `in_op` in 2: ALU select `{s1,s0}`: 00 AND, 01 OR, 10 XOR, 11 NOT A.
- `in_b` in WIDTH: operand B, or the load value.
- `alu_a` out WIDTH: to ALU `a`; always equals the accumulator.
- `alu_b` out WIDTH: to ALU `b`; latched operand B.
- `alu_s1`, `alu_s0` out 1 each: latched op bits.
- `alu_out` in WIDTH: ALU result.
- `res_valid` out 1: result available.
- `res_ready` in 1: downstream accepts the result when `res_valid && res_ready` at an edge.
- `res_data` out WIDTH: result value.
- `res_zero` out 1: `res_data == 0`.
- `op_count` out CNT_W: number of results consumed downstream.

## Operation
- FSM states: IDLE, EXEC, HOLD. Encodings live in the shared package.
- IDLE:
  - `in_ready=1`.
  - On handshake, latch `in_b` into `b_reg` and `in_op` into `op_reg`.
  - If `in_load`: `acc<=in_b`, `res_data<=in_b`, go to HOLD.
  - Otherwise go to EXEC.
- EXEC:
  - `in_ready=0`.
  - The ALU sees `acc`, `b_reg` and `op_reg` (all registered, stable for the whole cycle).
  - At the edge: `acc<=alu_out`, `res_data<=alu_out`, go to HOLD.
- HOLD:
  - `res_valid=1`, `in_ready=0`.
  - On `res_ready`: `op_count<=op_count+1`, go to IDLE.
  - `res_data` and `res_zero` are held stable until that handshake.
- NOT A (op 11) ignores `b_reg`, but `b_reg` is still latched.
- `op_count` wraps 2^CNT_W−1 → 0 with no flag. Loads count as operations.
- `in_valid` while not in IDLE is ignored. The upstream source must hold the instruction.
- `res_ready` outside HOLD has no effect.
- `res_valid` is a registered state decode. `in_ready` is a combinational state decode; it must not depend on `in_valid`.

## Timing
- Reset values: state IDLE, `acc=0`, `b_reg=0`, `op_reg=00`, `res_data=0`, `res_valid=0`, `res_zero=1`, `op_count=0`, `in_ready=1`, `alu_a=0`, `alu_b=0`, `alu_s1=alu_s0=0`.
- ALU instruction accepted at edge N: EXEC during cycle N+1, `res_valid=1` from edge N+2.
- Load accepted at edge N: `res_valid=1` from edge N+1.
- Results consumed immediately give throughput of one ALU instruction per 3 cycles and one load per 2 cycles.
- Result handshake at edge M: `in_ready=1` in cycle M+1. There is no same-cycle accept/consume overlap.
- `rst_n` asserted in any state (including mid-EXEC) immediately forces the reset values. An in-flight instruction is discarded, not counted, and produces no result.
- Reset release is synchronised externally; the block requires no ordering of its own.

## Structure
- Package `alu_pkg`:
  - state enum (IDLE, EXEC, HOLD);
  - op constants `OP_AND=2'b00`, `OP_OR=2'b01`, `OP_XOR=2'b10`, `OP_NOT=2'b11`;
  - `WIDTH` default.
- No sub-module inside `alu_accumulator`.
- A top-level wrapper `alu_datapath` instantiates `alu_accumulator` and the existing `alu`. It connects `alu_a`/`alu_b`/`alu_s1`/`alu_s0` to the ALU inputs and ALU `out` to `alu_out`.

## Test plan
- Reset, then load 0011 → `res_valid` 1 cycle after accept, `res_data=0011`, `res_zero=0`, `op_count=1`.
- From acc 0011: AND 0100 → `res_data=0000`, `res_zero=1`; reload 0011, OR 0100 → 0111; reload 0011, XOR 0100 → 0111; reload 0011, NOT → 1100. Each ALU result appears 2 cycles after accept.
- Chaining: load 0011, XOR 0100 (→0111), XOR 0100 → `res_data=0011`. Confirms accumulator feedback.
- Backpressure: hold `res_ready=0` for 5 cycles in HOLD → `res_data`/`res_valid` stable, `in_ready=0`, a concurrent `in_valid` is ignored, `op_count` unchanged.
- Reset mid-EXEC: assert `rst_n=0` during EXEC → all outputs at reset values before the next edge, no `res_valid`, `op_count=0`.
- Counter wrap with `CNT_W=2`: 4 consumed loads → `op_count` goes 1, 2, 3, 0.
